// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants, state encoding and lane payload type for the serial-to-parallel receiver.
package serial_paralelo_rx_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LANES          = 4;
  localparam int unsigned LANE_W         = $clog2(LANES);
  localparam int unsigned BIT_CNT_W      = $clog2(BYTE_W);
  localparam logic [BYTE_W-1:0] COM_DEF  = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    COUNT    = 2'd1,
    LOCKED   = 2'd2
  } align_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              valid;
  } lane_t;

  // A lane byte is valid unless it is the idle/comma symbol.
  function automatic lane_t make_lane(input logic [BYTE_W-1:0] b, input logic [BYTE_W-1:0] com);
    lane_t l;
    l.data  = b;
    l.valid = (b != com);
    return l;
  endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial line input plus the four recovered lanes and status flags of the receiver.
interface serial_paralelo_rx_if;
  import serial_paralelo_rx_pkg::*;

  logic              data_in;
  logic [BYTE_W-1:0] data_0;
  logic [BYTE_W-1:0] data_1;
  logic [BYTE_W-1:0] data_2;
  logic [BYTE_W-1:0] data_3;
  logic              valid_0;
  logic              valid_1;
  logic              valid_2;
  logic              valid_3;
  logic              active;
  logic              idle_out;

  // Link side: drives the serial line, consumes the lanes.
  modport master (
    output data_in,
    input  data_0, data_1, data_2, data_3,
    input  valid_0, valid_1, valid_2, valid_3,
    input  active, idle_out
  );

  // Deserializer side.
  modport slave (
    input  data_in,
    output data_0, data_1, data_2, data_3,
    output valid_0, valid_1, valid_2, valid_3,
    output active, idle_out
  );

endinterface

// File: rtl/serial_paralelo_rx_comma_aligner.sv
// Bit-level comma search: locks byte alignment after LOCK_COUNT consecutive aligned commas.
module serial_paralelo_rx_comma_aligner
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM        = COM_DEF,
  parameter int unsigned       LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  output logic [BYTE_W-1:0] byte_now_c,
  output logic              byte_done_c,
  output logic              active
);

  localparam int unsigned BC_W = $clog2(LOCK_COUNT + 1);

  // Only the seven newest bits are kept; the eighth comes straight from data_in.
  logic [BYTE_W-2:0]    sr;
  align_state_t         state, state_nx;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [BC_W-1:0]      bc_cnt, bc_cnt_nx;
  logic                 byte_end_c;

  assign byte_now_c  = {sr, data_in};
  assign byte_end_c  = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign byte_done_c = (state == LOCKED) && byte_end_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      state   <= UNLOCKED;
      bit_cnt <= '0;
      bc_cnt  <= '0;
      active  <= 1'b0;
    end else begin
      sr      <= byte_now_c[BYTE_W-2:0];
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      bc_cnt  <= bc_cnt_nx;
      active  <= (state_nx == LOCKED);
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    bc_cnt_nx  = bc_cnt;
    case (state)
      UNLOCKED: begin
        bit_cnt_nx = '0;
        bc_cnt_nx  = '0;
        if (byte_now_c == COM) begin
          state_nx  = COUNT;
          bc_cnt_nx = BC_W'(1);
        end
      end
      COUNT: begin
        bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
        if (byte_end_c) begin
          if (byte_now_c != COM) begin
            state_nx  = UNLOCKED;
            bc_cnt_nx = '0;
          end else if (bc_cnt == BC_W'(LOCK_COUNT - 1)) begin
            state_nx = LOCKED;
          end else begin
            bc_cnt_nx = bc_cnt + BC_W'(1);
          end
        end
      end
      LOCKED: begin
        // Counter wraps on the locking comma, so the next byte starts at bit 0.
        bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
      end
      default: begin
        state_nx = UNLOCKED;
      end
    endcase
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: aligns on commas, then splits the byte stream into four lanes per 32-bit frame.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM        = COM_DEF,
  parameter int unsigned       LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  bus
);

  logic [BYTE_W-1:0] byte_now_c;
  logic              byte_done_c;
  logic              active_q;
  logic [LANE_W-1:0] lane;
  logic [BYTE_W-1:0] lane_buf [LANES-1];
  lane_t             lane_q   [LANES];
  logic              idle_q;
  logic              frame_end_c;
  logic              frame_idle_c;

  serial_paralelo_rx_comma_aligner #(
    .COM        (COM),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_aligner (
    .clk         (clk_32f),
    .rst         (reset),
    .data_in     (bus.data_in),
    .byte_now_c  (byte_now_c),
    .byte_done_c (byte_done_c),
    .active      (active_q)
  );

  assign frame_end_c  = byte_done_c && (lane == LANE_W'(LANES - 1));
  assign frame_idle_c = (lane_buf[0] == COM) && (lane_buf[1] == COM) &&
                        (lane_buf[2] == COM) && (byte_now_c == COM);

  // Lanes 0..2 are buffered; lane 3 is taken live so the whole frame updates on its last bit.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      lane     <= '0;
      lane_buf <= '{default: '0};
      lane_q   <= '{default: '0};
      idle_q   <= 1'b0;
    end else if (byte_done_c) begin
      lane <= lane + LANE_W'(1);
      if (frame_end_c) begin
        lane_q[0] <= make_lane(lane_buf[0], COM);
        lane_q[1] <= make_lane(lane_buf[1], COM);
        lane_q[2] <= make_lane(lane_buf[2], COM);
        lane_q[3] <= make_lane(byte_now_c, COM);
        idle_q    <= frame_idle_c;
      end else begin
        lane_buf[lane] <= byte_now_c;
      end
    end
  end

  assign bus.data_0   = lane_q[0].data;
  assign bus.data_1   = lane_q[1].data;
  assign bus.data_2   = lane_q[2].data;
  assign bus.data_3   = lane_q[3].data;
  assign bus.valid_0  = lane_q[0].valid;
  assign bus.valid_1  = lane_q[1].valid;
  assign bus.valid_2  = lane_q[2].valid;
  assign bus.valid_3  = lane_q[3].valid;
  assign bus.active   = active_q;
  assign bus.idle_out = idle_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: bit streams checked cycle by cycle against a stream-level reference model.
module tb_serial_paralelo_rx;
  import serial_paralelo_rx_pkg::*;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         LC  = 4;

  logic clk_32f = 1'b0;
  logic reset;

  serial_paralelo_rx_if bus();

  serial_paralelo_rx dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int   total = 0;
  int   bad   = 0;
  logic stim [$];

  logic [7:0] e_data  [4];
  logic       e_valid [4];
  logic       e_act;
  logic       e_idle;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) stim.push_back(b[j]);
  endtask

  // Eight-bit window of the line ending at bit p; bits before the stream are zero (post-reset).
  function automatic logic [7:0] win(input int p);
    logic [7:0] w;
    w = '0;
    for (int j = p - 7; j <= p; j++)
      w = {w[6:0], (j >= 0 && j < stim.size()) ? stim[j] : 1'b0};
    return w;
  endfunction

  // Bit index where lock is reached, or -1: LC commas 8 bits apart; after a miss the search resumes one bit later.
  function automatic int find_lock();
    int  n;
    int  p;
    int  j;
    bit  fail;
    n = stim.size();
    p = 0;
    while (p < n) begin
      if (win(p) == COM) begin
        fail = 1'b0;
        for (j = 1; j < LC; j++) begin
          if (p + 8 * j >= n) return -1;
          if (win(p + 8 * j) != COM) begin
            fail = 1'b1;
            break;
          end
        end
        if (!fail) return p + 8 * (LC - 1);
        p = p + 8 * j + 1;
      end else begin
        p++;
      end
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    chk1({tag, ".active"},   bus.active,   e_act);
    chk1({tag, ".idle_out"}, bus.idle_out, e_idle);
    chk8({tag, ".data_0"},   bus.data_0,   e_data[0]);
    chk8({tag, ".data_1"},   bus.data_1,   e_data[1]);
    chk8({tag, ".data_2"},   bus.data_2,   e_data[2]);
    chk8({tag, ".data_3"},   bus.data_3,   e_data[3]);
    chk1({tag, ".valid_0"},  bus.valid_0,  e_valid[0]);
    chk1({tag, ".valid_1"},  bus.valid_1,  e_valid[1]);
    chk1({tag, ".valid_2"},  bus.valid_2,  e_valid[2]);
    chk1({tag, ".valid_3"},  bus.valid_3,  e_valid[3]);
  endtask

  task automatic check_cleared(input string tag);
    chk1({tag, ".active"},   bus.active,   1'b0);
    chk1({tag, ".idle_out"}, bus.idle_out, 1'b0);
    chk8({tag, ".data_0"},   bus.data_0,   8'h00);
    chk8({tag, ".data_1"},   bus.data_1,   8'h00);
    chk8({tag, ".data_2"},   bus.data_2,   8'h00);
    chk8({tag, ".data_3"},   bus.data_3,   8'h00);
    chk1({tag, ".valid_0"},  bus.valid_0,  1'b0);
    chk1({tag, ".valid_1"},  bus.valid_1,  1'b0);
    chk1({tag, ".valid_2"},  bus.valid_2,  1'b0);
    chk1({tag, ".valid_3"},  bus.valid_3,  1'b0);
  endtask

  // Drive stim one bit per clock; after each edge the outputs must match the frame model.
  task automatic run_stream(input string tag);
    int         n;
    int         q;
    logic [7:0] b;
    bit         all_com;
    n = stim.size();
    q = find_lock();
    e_act  = 1'b0;
    e_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e_data[k]  = 8'h00;
      e_valid[k] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk_32f);
      if (i > 0) check_outputs($sformatf("%s@%0d", tag, i - 1));
      bus.data_in = stim[i];
      if (q >= 0 && i >= q) e_act = 1'b1;
      if (q >= 0 && i > q && (i - q) % 32 == 0) begin
        all_com = 1'b1;
        for (int k = 0; k < 4; k++) begin
          b = win(i - 24 + 8 * k);
          e_data[k]  = b;
          e_valid[k] = (b != COM);
          all_com    = all_com && (b == COM);
        end
        e_idle = all_com;
      end
    end
    @(negedge clk_32f);
    check_outputs($sformatf("%s@%0d", tag, n - 1));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk_32f);
    reset       = 1'b1;
    bus.data_in = 1'b0;
    #1;
    check_cleared(tag);
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    check_cleared("reset_hold");
    reset = 1'b0;

    // Idle line after reset: nothing locks, outputs stay zero.
    stim.delete();
    for (int i = 0; i < 100; i++) stim.push_back(1'b0);
    run_stream("idle");
    chk1("idle.active_final", bus.active, 1'b0);
    pulse_reset("rst1");

    // Random bit offset, four commas, one data frame.
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(1'($urandom_range(0, 1)));
    repeat (4) push_byte(COM);
    push_byte(8'h12); push_byte(8'h34); push_byte(COM); push_byte(8'hFF);
    push_byte(8'h00);
    run_stream("lock");
    chk8("lock.d0", bus.data_0, 8'h12);
    chk8("lock.d1", bus.data_1, 8'h34);
    chk8("lock.d2", bus.data_2, 8'hBC);
    chk8("lock.d3", bus.data_3, 8'hFF);
    chk1("lock.v0", bus.valid_0, 1'b1);
    chk1("lock.v1", bus.valid_1, 1'b1);
    chk1("lock.v2", bus.valid_2, 1'b0);
    chk1("lock.v3", bus.valid_3, 1'b1);
    chk1("lock.idle", bus.idle_out, 1'b0);
    chk1("lock.active", bus.active, 1'b1);
    pulse_reset("rst2");

    // Interrupted comma run, then lock, an idle frame and an all-zero frame.
    stim.delete();
    repeat (3) push_byte(COM);
    push_byte(8'h55);
    repeat (4) push_byte(COM);
    repeat (4) push_byte(COM);
    repeat (4) push_byte(8'h00);
    run_stream("relock");
    chk8("zero.d0", bus.data_0, 8'h00);
    chk8("zero.d3", bus.data_3, 8'h00);
    chk1("zero.v0", bus.valid_0, 1'b1);
    chk1("zero.v1", bus.valid_1, 1'b1);
    chk1("zero.v2", bus.valid_2, 1'b1);
    chk1("zero.v3", bus.valid_3, 1'b1);
    chk1("zero.idle", bus.idle_out, 1'b0);
    chk1("zero.active", bus.active, 1'b1);
    pulse_reset("rst3");

    // Three random frames back to back, then a reset 13 bits into the fourth.
    stim.delete();
    repeat (4) push_byte(COM);
    for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 13; i++) stim.push_back(1'($urandom_range(0, 1)));
    run_stream("frames");
    chk1("frames.active", bus.active, 1'b1);
    pulse_reset("midframe");

    // After the mid-frame reset, three commas are not enough; four fresh ones are.
    stim.delete();
    repeat (3) push_byte(COM);
    push_byte(8'h00);
    repeat (4) push_byte(COM);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    run_stream("after_rst");
    chk1("after_rst.active", bus.active, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
